// File: rtl/glitch_free_clock_mux_n.sv
// glitch_free_clock_mux_n: N-input glitch-free clock multiplexer.
// Ports: clocka/reset_n control domain; clk_in[NUM_CLK] sources;
//   sel_req/sel request strobe and target; sel_ack/req_drop pulses;
//   busy, cur_sel and sticky timeout_err status; clock_out muxed clock.
module glitch_free_clock_mux_n #(
   parameter int NUM_CLK     = 4,
   parameter int SEL_W       = 2,
   parameter int SYNC_STAGES = 2,
   parameter int RESET_SEL   = 0,
   parameter int TIMEOUT     = 64
) (
   input  logic               clocka,
   input  logic               reset_n,
   input  logic [NUM_CLK-1:0] clk_in,
   input  logic               sel_req,
   input  logic [SEL_W-1:0]   sel,
   output logic               sel_ack,
   output logic               req_drop,
   output logic               busy,
   output logic [SEL_W-1:0]   cur_sel,
   output logic               timeout_err,
   output logic               clock_out
);

   localparam int CNT_W = $clog2(TIMEOUT) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST =
      CNT_W'(TIMEOUT - 1);
   localparam logic [SEL_W-1:0] SEL_RST =
      SEL_W'(RESET_SEL);
   localparam logic [NUM_CLK-1:0] EN_RST =
      NUM_CLK'(1) << RESET_SEL;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DISABLE,
      ST_ENABLE,
      ST_DONE
   } state_t;

   state_t             state_q;
   state_t             state_d;
   logic [NUM_CLK-1:0] en_req_q;
   logic [NUM_CLK-1:0] en_req_d;
   logic [SEL_W-1:0]   cur_sel_d;
   logic [SEL_W-1:0]   target_q;
   logic [SEL_W-1:0]   target_d;
   logic [CNT_W-1:0]   cnt_q;
   logic [CNT_W-1:0]   cnt_d;
   logic               ack_d;
   logic               drop_d;
   logic               terr_d;
   logic               boot_q;
   logic               boot_d;
   logic [NUM_CLK-1:0] gate_en;
   logic [NUM_CLK-1:0] stat_meta;
   logic [NUM_CLK-1:0] en_stat;
   logic               stat_cur;
   logic               stat_tgt;
   logic               sel_ok;

   // Per-source enable path: posedge synchronizer, then a
   // negedge flop so the gate only moves while its clock is low.
   for (genvar i = 0; i < NUM_CLK; i++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_q;
      logic                   gate_q;

      always_ff @(posedge clk_in[i] or negedge reset_n) begin
         if (!reset_n) begin
            sync_q <= '0;
         end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], en_req_q[i]};
         end
      end

      always_ff @(negedge clk_in[i] or negedge reset_n) begin
         if (!reset_n) begin
            gate_q <= 1'b0;
         end else begin
            gate_q <= sync_q[SYNC_STAGES-1];
         end
      end

      assign gate_en[i] = gate_q;
   end

   assign clock_out = |(clk_in & gate_en);

   always_ff @(posedge clocka or negedge reset_n) begin
      if (!reset_n) begin
         stat_meta <= '0;
         en_stat   <= '0;
      end else begin
         stat_meta <= gate_en;
         en_stat   <= stat_meta;
      end
   end

   always_comb begin
      stat_cur = 1'b0;
      stat_tgt = 1'b0;
      for (int i = 0; i < NUM_CLK; i++) begin
         if (SEL_W'(i) == cur_sel) stat_cur = en_stat[i];
         if (SEL_W'(i) == target_q) stat_tgt = en_stat[i];
      end
   end

   assign sel_ok = (32'(sel) < NUM_CLK);
   assign busy   = (state_q != ST_IDLE);

   always_comb begin
      state_d   = state_q;
      en_req_d  = en_req_q;
      cur_sel_d = cur_sel;
      target_d  = target_q;
      cnt_d     = cnt_q;
      ack_d     = 1'b0;
      drop_d    = 1'b0;
      terr_d    = timeout_err;
      boot_d    = boot_q;

      if (sel_req && (state_q != ST_IDLE)) drop_d = 1'b1;

      unique case (state_q)
         ST_IDLE: begin
            if (sel_req) begin
               if (!sel_ok) begin
                  drop_d = 1'b1;
               end else if (sel == cur_sel) begin
                  ack_d = 1'b1;
               end else begin
                  // Only cur_sel is set, so clearing all is exact.
                  target_d = sel;
                  terr_d   = 1'b0;
                  en_req_d = '0;
                  cnt_d    = '0;
                  state_d  = ST_DISABLE;
               end
            end
         end
         ST_DISABLE: begin
            cnt_d = cnt_q + 1'b1;
            if (!stat_cur || (cnt_q == CNT_LAST)) begin
               // A dead old clock is abandoned after the timeout.
               if (stat_cur) terr_d = 1'b1;
               for (int i = 0; i < NUM_CLK; i++) begin
                  en_req_d[i] = (SEL_W'(i) == target_q);
               end
               cnt_d   = '0;
               state_d = ST_ENABLE;
            end
         end
         ST_ENABLE: begin
            cnt_d = cnt_q + 1'b1;
            if (stat_tgt || (cnt_q == CNT_LAST)) begin
               if (!stat_tgt) terr_d = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            cur_sel_d = target_q;
            // The start-up enable after reset is not acknowledged.
            if (boot_q) boot_d = 1'b0;
            else        ack_d  = 1'b1;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clocka or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_ENABLE;
         en_req_q    <= EN_RST;
         cur_sel     <= SEL_RST;
         target_q    <= SEL_RST;
         cnt_q       <= '0;
         sel_ack     <= 1'b0;
         req_drop    <= 1'b0;
         timeout_err <= 1'b0;
         boot_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         en_req_q    <= en_req_d;
         cur_sel     <= cur_sel_d;
         target_q    <= target_d;
         cnt_q       <= cnt_d;
         sel_ack     <= ack_d;
         req_drop    <= drop_d;
         timeout_err <= terr_d;
         boot_q      <= boot_d;
      end
   end

endmodule

// File: tb/tb_glitch_free_clock_mux_n.sv
// tb_glitch_free_clock_mux_n: directed bench for the N-input clock mux.
// Sources run at 100/140/220/60 time units; clocka at 40 units.
module tb_glitch_free_clock_mux_n;

   logic       clocka;
   logic       reset_n;
   logic [3:0] clk_in;
   logic       sel_req;
   logic [2:0] sel;
   logic       sel_ack;
   logic       req_drop;
   logic       busy;
   logic [2:0] cur_sel;
   logic       timeout_err;
   logic       clock_out;

   logic c0 = 1'b0;
   logic c1 = 1'b0;
   logic c2 = 1'b0;
   logic c3 = 1'b0;
   logic run0 = 1'b1;

   int errors = 0;
   int checks = 0;
   int ack_cnt = 0;
   int drop_cnt = 0;

   longint t_rise = 0;
   longint t_fall = 0;
   longint min_high = 1000000;
   longint max_low = 0;

   glitch_free_clock_mux_n #(
      .NUM_CLK(4),
      .SEL_W(3),
      .SYNC_STAGES(2),
      .RESET_SEL(0),
      .TIMEOUT(64)
   ) dut (
      .clocka(clocka),
      .reset_n(reset_n),
      .clk_in(clk_in),
      .sel_req(sel_req),
      .sel(sel),
      .sel_ack(sel_ack),
      .req_drop(req_drop),
      .busy(busy),
      .cur_sel(cur_sel),
      .timeout_err(timeout_err),
      .clock_out(clock_out)
   );

   // clocka edges sit at 5 mod 10, source edges at 0 mod 10.
   initial begin
      clocka = 1'b0;
      #5;
      forever #20 clocka = ~clocka;
   end

   always #50 c0 = run0 ? ~c0 : 1'b0;
   always #70 c1 = ~c1;
   always #110 c2 = ~c2;
   always #30 c3 = ~c3;
   assign clk_in = {c3, c2, c1, c0};

   always @(posedge clock_out) begin
      t_rise = $time;
      if ($time - t_fall > max_low) max_low = $time - t_fall;
   end

   always @(negedge clock_out) begin
      if ($time - t_rise < min_high) min_high = $time - t_rise;
      t_fall = $time;
   end

   always @(posedge clocka) begin
      if (sel_ack) ack_cnt++;
      if (req_drop) drop_cnt++;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic pulse_req(input logic [2:0] s);
      @(negedge clocka);
      sel_req = 1'b1;
      sel = s;
      @(negedge clocka);
      sel_req = 1'b0;
   endtask

   task automatic wait_idle(input int max_cyc,
                            output int n, output bit ok);
      n = 0;
      ok = 1'b0;
      while (n < max_cyc) begin
         @(negedge clocka);
         n++;
         if (!busy) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic count_follow(input int k, input int cyc,
                               output int bad);
      bad = 0;
      repeat (cyc) begin
         @(negedge clocka);
         if (clock_out !== clk_in[k]) bad++;
      end
   endtask

   task automatic mon_clear();
      min_high = 1000000;
      max_low = 0;
      t_fall = $time;
   endtask

   task automatic test_reset();
      int hi;
      reset_n = 1'b0;
      sel_req = 1'b0;
      sel = '0;
      hi = 0;
      repeat (12) begin
         @(negedge clocka);
         if (clock_out !== 1'b0) hi++;
      end
      checks++;
      if (hi !== 0) begin
         errors++;
         $display("FAIL reset_clock_out: high samples %0d want 0", hi);
      end
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL reset_busy: got %b want 1", busy);
      end
      checks++;
      if (cur_sel !== 3'd0) begin
         errors++;
         $display("FAIL reset_cur_sel: got %0d want 0", cur_sel);
      end
      checks++;
      if ({sel_ack, req_drop, timeout_err} !== 3'b000) begin
         errors++;
         $display("FAIL reset_flags: ack/drop/terr %b want 000",
                  {sel_ack, req_drop, timeout_err});
      end
   endtask

   task automatic test_startup();
      int a0;
      int n;
      int bad;
      bit ok;
      a0 = ack_cnt;
      @(negedge clocka);
      reset_n = 1'b1;
      wait_idle(100, n, ok);
      checks++;
      if (ok !== 1'b1) begin
         errors++;
         $display("FAIL startup_idle: busy still %b after %0d", busy, n);
      end
      checks++;
      if (cur_sel !== 3'd0) begin
         errors++;
         $display("FAIL startup_cur_sel: got %0d want 0", cur_sel);
      end
      count_follow(0, 20, bad);
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL startup_follow: %0d bad samples want 0", bad);
      end
      checks++;
      if (ack_cnt - a0 !== 0) begin
         errors++;
         $display("FAIL startup_no_ack: acks %0d want 0", ack_cnt - a0);
      end
   endtask

   task automatic test_switch();
      int a0;
      int n;
      int bad;
      bit ok;
      a0 = ack_cnt;
      mon_clear();
      pulse_req(3'd2);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL switch_busy: got %b want 1", busy);
      end
      wait_idle(300, n, ok);
      checks++;
      if (ok !== 1'b1 || sel_ack !== 1'b1 || cur_sel !== 3'd2) begin
         errors++;
         $display("FAIL switch_done: ok %b ack %b cur %0d want 1 1 2",
                  ok, sel_ack, cur_sel);
      end
      repeat (2) @(negedge clocka);
      checks++;
      if (ack_cnt - a0 !== 1) begin
         errors++;
         $display("FAIL switch_acks: got %0d want 1", ack_cnt - a0);
      end
      checks++;
      if (timeout_err !== 1'b0) begin
         errors++;
         $display("FAIL switch_terr: got %b want 0", timeout_err);
      end
      checks++;
      if (min_high < 50) begin
         errors++;
         $display("FAIL switch_min_high: got %0d want >=50", min_high);
      end
      checks++;
      if (max_low < 300) begin
         errors++;
         $display("FAIL switch_gap: got %0d want >=300", max_low);
      end
      count_follow(2, 20, bad);
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL switch_follow: %0d bad samples want 0", bad);
      end
   endtask

   task automatic test_same_invalid();
      int a0;
      int d0;
      a0 = ack_cnt;
      d0 = drop_cnt;
      pulse_req(3'd2);
      checks++;
      if (sel_ack !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL same_ack: ack %b busy %b want 1 0",
                  sel_ack, busy);
      end
      pulse_req(3'd5);
      checks++;
      if (req_drop !== 1'b1 || sel_ack !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL invalid_drop: drop %b ack %b busy %b want 1 0 0",
                  req_drop, sel_ack, busy);
      end
      repeat (2) @(negedge clocka);
      checks++;
      if (ack_cnt - a0 !== 1 || drop_cnt - d0 !== 1) begin
         errors++;
         $display("FAIL same_invalid_counts: acks %0d drops %0d want 1 1",
                  ack_cnt - a0, drop_cnt - d0);
      end
      checks++;
      if (cur_sel !== 3'd2) begin
         errors++;
         $display("FAIL same_invalid_cur: got %0d want 2", cur_sel);
      end
   endtask

   task automatic test_back_to_back();
      int a0;
      int d0;
      int n;
      int bad;
      bit ok;
      a0 = ack_cnt;
      d0 = drop_cnt;
      mon_clear();
      pulse_req(3'd3);
      repeat (2) @(negedge clocka);
      pulse_req(3'd1);
      checks++;
      if (req_drop !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL b2b_drop: drop %b busy %b want 1 1",
                  req_drop, busy);
      end
      wait_idle(300, n, ok);
      checks++;
      if (ok !== 1'b1 || cur_sel !== 3'd3) begin
         errors++;
         $display("FAIL b2b_done: ok %b cur %0d want 1 3", ok, cur_sel);
      end
      repeat (2) @(negedge clocka);
      checks++;
      if (ack_cnt - a0 !== 1 || drop_cnt - d0 !== 1) begin
         errors++;
         $display("FAIL b2b_counts: acks %0d drops %0d want 1 1",
                  ack_cnt - a0, drop_cnt - d0);
      end
      checks++;
      if (min_high < 30) begin
         errors++;
         $display("FAIL b2b_min_high: got %0d want >=30", min_high);
      end
      count_follow(3, 20, bad);
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL b2b_follow: %0d bad samples want 0", bad);
      end
   endtask

   task automatic test_timeout();
      int a0;
      int n;
      int bad;
      bit ok;
      pulse_req(3'd0);
      wait_idle(300, n, ok);
      repeat (2) @(negedge clocka);
      run0 = 1'b0;
      repeat (10) @(negedge clocka);
      a0 = ack_cnt;
      pulse_req(3'd1);
      n = 0;
      while (n < 100) begin
         @(negedge clocka);
         n++;
         if (timeout_err) break;
      end
      checks++;
      if (n !== 64) begin
         errors++;
         $display("FAIL timeout_cycles: got %0d want 64", n);
      end
      wait_idle(300, n, ok);
      checks++;
      if (ok !== 1'b1 || cur_sel !== 3'd1) begin
         errors++;
         $display("FAIL timeout_done: ok %b cur %0d want 1 1",
                  ok, cur_sel);
      end
      repeat (2) @(negedge clocka);
      checks++;
      if (timeout_err !== 1'b1 || ack_cnt - a0 !== 1) begin
         errors++;
         $display("FAIL timeout_sticky: terr %b acks %0d want 1 1",
                  timeout_err, ack_cnt - a0);
      end
      count_follow(1, 20, bad);
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL timeout_follow: %0d bad samples want 0", bad);
      end
      run0 = 1'b1;
      repeat (30) @(negedge clocka);
      pulse_req(3'd2);
      checks++;
      if (timeout_err !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL timeout_clear: terr %b busy %b want 0 1",
                  timeout_err, busy);
      end
      wait_idle(300, n, ok);
      checks++;
      if (ok !== 1'b1 || cur_sel !== 3'd2 || timeout_err !== 1'b0) begin
         errors++;
         $display("FAIL timeout_next: ok %b cur %0d terr %b want 1 2 0",
                  ok, cur_sel, timeout_err);
      end
      repeat (2) @(negedge clocka);
   endtask

   task automatic test_reset_mid_switch();
      int a0;
      int n;
      int lowrun;
      int bad;
      bit ok;
      bit found;
      pulse_req(3'd0);
      wait_idle(300, n, ok);
      repeat (2) @(negedge clocka);
      a0 = ack_cnt;
      pulse_req(3'd3);
      lowrun = 0;
      found = 1'b0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clocka);
         if (!clock_out) lowrun++;
         else lowrun = 0;
         if (lowrun >= 3) begin
            found = 1'b1;
            break;
         end
      end
      checks++;
      if (found !== 1'b1) begin
         errors++;
         $display("FAIL midrst_gap: no low gap seen, got %b want 1",
                  found);
      end
      found = 1'b0;
      for (int k = 0; k < 2000; k++) begin
         #1;
         if (clock_out) begin
            found = 1'b1;
            break;
         end
      end
      checks++;
      if (found !== 1'b1) begin
         errors++;
         $display("FAIL midrst_new_pulse: got %b want 1", found);
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if (clock_out !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL midrst_async: clk %b busy %b want 0 1",
                  clock_out, busy);
      end
      checks++;
      if (cur_sel !== 3'd0 || sel_ack !== 1'b0) begin
         errors++;
         $display("FAIL midrst_state: cur %0d ack %b want 0 0",
                  cur_sel, sel_ack);
      end
      repeat (3) @(negedge clocka);
      reset_n = 1'b1;
      wait_idle(100, n, ok);
      checks++;
      if (ok !== 1'b1 || cur_sel !== 3'd0) begin
         errors++;
         $display("FAIL midrst_resume: ok %b cur %0d want 1 0",
                  ok, cur_sel);
      end
      count_follow(0, 20, bad);
      checks++;
      if (bad !== 0 || ack_cnt - a0 !== 0) begin
         errors++;
         $display("FAIL midrst_follow: bad %0d acks %0d want 0 0",
                  bad, ack_cnt - a0);
      end
   endtask

   initial begin
      test_reset();
      test_startup();
      test_switch();
      test_same_invalid();
      test_back_to_back();
      test_timeout();
      test_reset_mid_switch();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
